m_dram_arbiter_n: RTL
=====================

// Module: m_dram_arbiter_n
// PURPOSE
// - Parametrised N-hart DRAM port arbiter. Generalises the single-hart CPU+MMU DRAM path to NCH masters.
// - Each channel connects to one CPU+MMU w_dram_* port set. The arbiter serialises the channels onto one DRAM controller.
// - Arbitration is round-robin with one outstanding DRAM transaction at a time.
// - Sits between the per-hart CPU+MMU instances and the single DRAM controller in the SoC top.
// PARAMETERS
// - NCH  2   number of master channels (1..8)
// - AW   32  address width
// - DW   32  data width
// - CW   3   ctrl width (size/sign code, forwarded unchanged)
// PORTS
// - CLK            in   1       clock
// - RST_X          in   1       asynchronous reset, active-low
// - w_ch_addr      in   NCH*AW  per-channel address; channel i at [i*AW +: AW]
// - w_ch_wdata     in   NCH*DW  per-channel write data
// - w_ch_ctrl      in   NCH*CW  per-channel ctrl
// - w_ch_le        in   NCH     per-channel 1-cycle load-request pulse
// - w_ch_we        in   NCH     per-channel 1-cycle store-request pulse
// - w_ch_busy      out  NCH     per-channel busy (request pending or in flight)
// - w_ch_odata     out  NCH*DW  per-channel load data, held until that channel's next load completes
// - w_dram_addr    out  AW      to DRAM controller
// - w_dram_wdata   out  DW      to DRAM controller
// - w_dram_ctrl    out  CW      to DRAM controller
// - w_dram_le      out  1       1-cycle load pulse
// - w_dram_we_t    out  1       1-cycle store pulse
// - w_dram_odata   in   DW      DRAM read data, valid when busy falls
// - w_dram_busy    in   1       controller busy; rises the cycle after a le/we pulse
// - w_grant_cnt    out  NCH*32  per-channel grant counters (see CONFIGURATION)
// BEHAVIOUR
// - Reset values: all outputs 0; pending regs 0; rr pointer 0; state IDLE. Reset mid-transaction discards everything.
// - Capture: le or we at cycle t sets pending[i] and latches addr, wdata, ctrl and dir at t+1.
//   - w_ch_busy[i] = pending[i] | (active & grant==i), combinational from registers.
//   - A pulse while w_ch_busy[i]=1 is a protocol violation and is ignored; latched values are not modified.
//   - le and we together on one channel is treated as a store.
// - FSM IDLE:
//   - If any pending, grant = first pending index at or after rr_ptr, wrapping modulo NCH.
//   - Clear pending[grant], set active, go to ISSUE.
// - FSM ISSUE (1 cycle):
//   - Drive w_dram_addr, w_dram_wdata and w_dram_ctrl from the granted latch.
//   - Pulse w_dram_le or w_dram_we_t for exactly 1 cycle. Go to WAIT.
//   - w_dram_addr, w_dram_wdata and w_dram_ctrl hold stable from ISSUE through the end of WAIT.
// - FSM WAIT:
//   - Stay while w_dram_busy=1. The first WAIT cycle is the one after ISSUE.
//   - On w_dram_busy=0: for a load, w_ch_odata[grant] <= w_dram_odata.
//   - Then clear active, rr_ptr <= (grant+1) mod NCH, go to IDLE.
// - Latency: request at t -> DRAM pulse at t+2 -> w_ch_busy falls one cycle after the busy-low WAIT cycle.
//   - Uncontended minimum is 4 cycles request-to-free when the controller holds busy for 1 cycle.
// - Simultaneous requests: all captured the same cycle, then served in rr order.
// - A channel's new request may be captured the cycle its busy falls.
// - NCH=1: rr_ptr is constant 0, and behaviour is otherwise identical.
// CONFIGURATION
// - Macro ARB_GRANT_CNT_EN defined: w_grant_cnt[i] is a 32-bit counter.
//   - Increments on each IDLE->ISSUE grant to channel i, wraps at 2^32, reset 0.
// - Not defined: w_grant_cnt is tied to 0 and no counter flops are built. Arbitration is unaffected.
// TESTING
// - Single load ch0 addr=0x80001000, dram busy 3 cycles, odata=0xDEADBEEF -> one le pulse; ch0 odata=0xDEADBEEF; ch0 busy 6 cycles.
// - NCH=4, ch0..3 store pulses same cycle -> we_t pulses in order ch0,1,2,3; each pulse carries that channel's addr/wdata.
// - rr fairness: ch1 and ch0 request continuously -> grants alternate 1,0,1,0 after the first grant (rr_ptr starts 0, so ch0 first).
// - Violation: ch0 pulses le again while busy with a different addr -> ignored; only the original addr reaches DRAM.
// - Reset asserted during WAIT with ch1 pending -> all outputs 0 immediately; no DRAM pulse after release until a new request.
// - ARB_GRANT_CNT_EN: 5 grants ch0 and 3 grants ch1 -> w_grant_cnt = {32'd3, 32'd5}. Without the macro -> 0.

Source files
------------

// File: rtl/m_dram_arbiter_n.sv
// m_dram_arbiter_n: round-robin arbiter that serialises NCH CPU+MMU DRAM
// request channels onto a single DRAM controller, one transaction in flight.
// Optional build macro ARB_GRANT_CNT_EN adds per-channel 32-bit grant
// counters on w_grant_cnt; when it is undefined that port is tied to zero.
module m_dram_arbiter_n #(
   parameter int NCH = 2,
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int CW  = 3
) (
   input  logic              CLK,
   input  logic              RST_X,
   input  logic [NCH*AW-1:0] w_ch_addr,
   input  logic [NCH*DW-1:0] w_ch_wdata,
   input  logic [NCH*CW-1:0] w_ch_ctrl,
   input  logic [NCH-1:0]    w_ch_le,
   input  logic [NCH-1:0]    w_ch_we,
   output logic [NCH-1:0]    w_ch_busy,
   output logic [NCH*DW-1:0] w_ch_odata,
   output logic [AW-1:0]     w_dram_addr,
   output logic [DW-1:0]     w_dram_wdata,
   output logic [CW-1:0]     w_dram_ctrl,
   output logic              w_dram_le,
   output logic              w_dram_we_t,
   input  logic [DW-1:0]     w_dram_odata,
   input  logic              w_dram_busy,
   output logic [NCH*32-1:0] w_grant_cnt
);

   localparam int          GW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned NCHU = NCH;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]     state;
   logic           active;
   logic [GW-1:0]  grant;
   logic [GW-1:0]  rr_ptr;
   logic [GW-1:0]  sel;
   logic           sel_vld;
   logic [GW-1:0]  nxt_ptr;
   logic [NCH-1:0] pending;
   logic [NCH-1:0] pend_clr;
   logic [NCH-1:0] cap;

   logic [AW-1:0]  lat_addr  [NCH];
   logic [DW-1:0]  lat_wdata [NCH];
   logic [CW-1:0]  lat_ctrl  [NCH];
   logic [NCH-1:0] lat_dir;
   logic [DW-1:0]  odata_r   [NCH];

   // Busy per channel: waiting for a grant or currently owning the DRAM port
   always_comb begin
      w_ch_busy = '0;
      for (int unsigned i = 0; i < NCHU; i++) begin
         w_ch_busy[i] = pending[i] | (active & (grant == GW'(i)));
      end
   end

   // Requests are only accepted from idle channels; le+we together counts as store
   always_comb begin
      cap = (w_ch_le | w_ch_we) & ~w_ch_busy;
   end

   // Round-robin pick: first pending channel at or after rr_ptr, wrapping
   always_comb begin
      int unsigned idx;
      sel     = '0;
      sel_vld = 1'b0;
      idx     = 0;
      for (int unsigned k = 0; k < NCHU; k++) begin
         idx = (32'(rr_ptr) + k) % NCHU;
         if (!sel_vld && pending[idx]) begin
            sel     = GW'(idx);
            sel_vld = 1'b1;
         end
      end
   end

   // Pending bit to drop on the cycle a grant is made, and next rr pointer
   always_comb begin
      pend_clr = '0;
      if (state == S_IDLE && sel_vld) begin
         pend_clr[sel] = 1'b1;
      end
      nxt_ptr = (grant == GW'(NCH - 1)) ? '0 : grant + GW'(1);
   end

   // Latch each accepted request's payload and direction
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         lat_dir <= '0;
         for (int unsigned i = 0; i < NCHU; i++) begin
            lat_addr[i]  <= '0;
            lat_wdata[i] <= '0;
            lat_ctrl[i]  <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NCHU; i++) begin
            if (cap[i]) begin
               lat_addr[i]  <= w_ch_addr[i*AW +: AW];
               lat_wdata[i] <= w_ch_wdata[i*DW +: DW];
               lat_ctrl[i]  <= w_ch_ctrl[i*CW +: CW];
               lat_dir[i]   <= w_ch_we[i];
            end
         end
      end
   end

   // Arbitration FSM: grant in IDLE, pulse in ISSUE, collect result in WAIT
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         state        <= S_IDLE;
         active       <= 1'b0;
         grant        <= '0;
         rr_ptr       <= '0;
         pending      <= '0;
         w_dram_addr  <= '0;
         w_dram_wdata <= '0;
         w_dram_ctrl  <= '0;
         w_dram_le    <= 1'b0;
         w_dram_we_t  <= 1'b0;
         for (int unsigned i = 0; i < NCHU; i++) begin
            odata_r[i] <= '0;
         end
      end else begin
         pending     <= (pending | cap) & ~pend_clr;
         w_dram_le   <= 1'b0;
         w_dram_we_t <= 1'b0;
         case (state)
            S_IDLE: begin
               // DRAM outputs are registered here so they are valid during ISSUE
               if (sel_vld) begin
                  grant        <= sel;
                  active       <= 1'b1;
                  w_dram_addr  <= lat_addr[sel];
                  w_dram_wdata <= lat_wdata[sel];
                  w_dram_ctrl  <= lat_ctrl[sel];
                  w_dram_le    <= ~lat_dir[sel];
                  w_dram_we_t  <= lat_dir[sel];
                  state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (!w_dram_busy) begin
                  if (!lat_dir[grant]) begin
                     odata_r[grant] <= w_dram_odata;
                  end
                  active <= 1'b0;
                  rr_ptr <= nxt_ptr;
                  state  <= S_IDLE;
               end
            end
            default: begin
               active <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   // Pack per-channel load data onto the flat output bus
   always_comb begin
      w_ch_odata = '0;
      for (int unsigned i = 0; i < NCHU; i++) begin
         w_ch_odata[i*DW +: DW] = odata_r[i];
      end
   end

`ifdef ARB_GRANT_CNT_EN
   logic [31:0] gcnt [NCH];

   // Count grants per channel, wrapping naturally at 2^32
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         for (int unsigned i = 0; i < NCHU; i++) begin
            gcnt[i] <= '0;
         end
      end else if (state == S_IDLE && sel_vld) begin
         gcnt[sel] <= gcnt[sel] + 32'd1;
      end
   end

   // Pack counters onto the flat output bus
   always_comb begin
      w_grant_cnt = '0;
      for (int unsigned i = 0; i < NCHU; i++) begin
         w_grant_cnt[i*32 +: 32] = gcnt[i];
      end
   end
`else
   assign w_grant_cnt = '0;
`endif

endmodule
